sobel_window_scanner: RTL and testbench
=======================================

// Module: sobel_window_scanner
// PURPOSE
//   Sequencer for the Sobel datapath. Walks every interior center pixel of a
//   WIDTH x HEIGHT frame in raster order and issues the 9 neighbour (row,column)
//   read requests of each 3x3 window to pixel memory over a valid/ready port.
//   After the 9th read of a window it hands the window center to the gradient
//   core and waits for the core to accept it.
// PARAMETERS
//   IMG_W    256  frame width in pixels (3..2**COORD_W)
//   IMG_H    256  frame height in pixels (3..2**COORD_W)
//   COORD_W  8    width of the row and column coordinates
// PORTS
//   Clk          in   1        rising-edge clock
//   Reset        in   1        asynchronous, active-high reset
//   Start        in   1        1-cycle request to scan a frame; ignored unless idle
//   Abort        in   1        synchronous abort; return to IDLE next cycle
//   Rd_Valid     out  1        read request valid
//   Rd_Ready     in   1        memory accepts the request this cycle
//   Rd_Row       out  COORD_W  row of the tap being requested
//   Rd_Column    out  COORD_W  column of the tap being requested
//   Rd_Tap       out  4        tap index 0..8, row-major inside the window
//   Win_Valid    out  1        all 9 taps issued; the window center is presented
//   Win_Ready    in   1        Sobel core accepts the window
//   Win_Row      out  COORD_W  center row of the completed window
//   Win_Column   out  COORD_W  center column of the completed window
//   Busy         out  1        scan in progress (not IDLE)
//   Done         out  1        1-cycle pulse after the last window is accepted
// BEHAVIOUR
//   - Reset (async): state IDLE, center=(1,1), tap=0; every output is 0.
//   - States: IDLE -> FETCH (on Start) -> PRESENT (tap 8 handshake) ->
//     FETCH (Win_Ready and not the last center) | FINISH (Win_Ready on the last
//     center) -> IDLE. FINISH lasts 1 cycle and asserts Done.
//   - FETCH: Rd_Valid=1. Rd_Row=cr-1+tap/3 and Rd_Column=cc-1+tap%3, both
//     computed at full COORD_W width; no wrap is possible because centers are
//     interior. The tap advances only on Rd_Valid&&Rd_Ready. Address and tap
//     hold stable while Rd_Ready=0.
//   - The handshake on tap 8 moves the block to PRESENT on the next cycle, so
//     Rd_Valid and Win_Valid are never high together. Minimum cost is 9 cycles
//     for the reads plus 1 cycle in PRESENT per window.
//   - PRESENT: Win_Valid=1. Win_Row and Win_Column equal the center and hold
//     until Win_Ready. On acceptance: cc+1. When cc==IMG_W-2, cc wraps to 1 and
//     cr increments. The tap resets to 0.
//   - Center order: rows 1..IMG_H-2, columns 1..IMG_W-2. Border pixels are never
//     centers. Total windows = (IMG_W-2)*(IMG_H-2).
//   - Start asserted while Busy=1 is ignored. Start and Abort together in IDLE:
//     Abort wins and the block stays IDLE.
//   - Abort in any state: next cycle is IDLE with center=(1,1) and tap=0. Done is
//     not pulsed. A pending handshake in the same cycle is discarded.
//   - Busy=1 in FETCH, PRESENT and FINISH.
//   - Reset mid-scan aborts immediately. The next scan starts at (1,1).
// TESTING
//   1 IMG_W=IMG_H=4, Start, Rd_Ready=Win_Ready=1 -> 36 reads. Windows in order
//     (1,1),(1,2),(2,1),(2,2). Done pulses once, 1 cycle after the 4th Win
//     handshake. 40 cycles from the first Rd_Valid to Done.
//   2 IMG_W=IMG_H=3 -> taps (0,0),(0,1),(0,2),(1,0)..(2,2) with Rd_Tap 0..8.
//     One window (1,1), then Done.
//   3 Rd_Ready random 50%, Win_Ready low for 5 cycles -> address, tap and
//     center stay stable while stalled. The read sequence matches case 1.
//   4 Abort during tap 4 of window (1,2) -> next cycle Busy=0, Rd_Valid=0, no
//     Done. A new Start begins again at (1,1), tap 0.
//   5 Start pulsed while Busy, and Reset asserted mid-FETCH -> the Start is
//     ignored. On Reset all outputs go to 0 immediately, with no clock edge.

Source files
------------

// File: rtl/sobel_window_scanner.sv
// rtl/sobel_window_scanner.sv - 3x3 window read sequencer for the Sobel datapath
//
// Walks every interior center (rows 1..IMG_H-2, columns 1..IMG_W-2) in raster
// order. For each center it issues nine tap reads, row-major inside the window,
// and then presents the center to the gradient core.
//
// Ports:
//   Clk, Reset              clock, asynchronous active-high reset
//   Start, Abort            scan request (ignored unless idle), synchronous abort
//   Rd_Valid/Rd_Ready       tap read handshake; Rd_Row, Rd_Column, Rd_Tap describe the tap
//   Win_Valid/Win_Ready     window handshake; Win_Row, Win_Column give the window center
//   Busy                    high whenever the scanner is not idle
//   Done                    1-cycle pulse after the last window is accepted
module sobel_window_scanner #(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int COORD_W = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Abort,
  output logic               Rd_Valid,
  input  logic               Rd_Ready,
  output logic [COORD_W-1:0] Rd_Row,
  output logic [COORD_W-1:0] Rd_Column,
  output logic [3:0]         Rd_Tap,
  output logic               Win_Valid,
  input  logic               Win_Ready,
  output logic [COORD_W-1:0] Win_Row,
  output logic [COORD_W-1:0] Win_Column,
  output logic               Busy,
  output logic               Done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_FINISH
  } state_t;

  localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W - 2);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_H - 2);

  state_t               state_q, state_d;
  logic [COORD_W-1:0]   cr_q, cr_d;
  logic [COORD_W-1:0]   cc_q, cc_d;
  logic [3:0]           tap_q, tap_d;
  logic [COORD_W-1:0]   tap_dr, tap_dc;

  // Row and column offset of the tap inside the window (tap/3, tap%3).
  always_comb begin
    tap_dr = '0;
    tap_dc = '0;
    case (tap_q)
      4'd0: begin tap_dr = COORD_W'(0); tap_dc = COORD_W'(0); end
      4'd1: begin tap_dr = COORD_W'(0); tap_dc = COORD_W'(1); end
      4'd2: begin tap_dr = COORD_W'(0); tap_dc = COORD_W'(2); end
      4'd3: begin tap_dr = COORD_W'(1); tap_dc = COORD_W'(0); end
      4'd4: begin tap_dr = COORD_W'(1); tap_dc = COORD_W'(1); end
      4'd5: begin tap_dr = COORD_W'(1); tap_dc = COORD_W'(2); end
      4'd6: begin tap_dr = COORD_W'(2); tap_dc = COORD_W'(0); end
      4'd7: begin tap_dr = COORD_W'(2); tap_dc = COORD_W'(1); end
      default: begin tap_dr = COORD_W'(2); tap_dc = COORD_W'(2); end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cr_q    <= ONE;
      cc_q    <= ONE;
      tap_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cr_q    <= cr_d;
      cc_q    <= cc_d;
      tap_q   <= tap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cr_d       = cr_q;
    cc_d       = cc_q;
    tap_d      = tap_q;
    Rd_Valid   = 1'b0;
    Rd_Row     = '0;
    Rd_Column  = '0;
    Rd_Tap     = 4'd0;
    Win_Valid  = 1'b0;
    Win_Row    = '0;
    Win_Column = '0;
    Done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_FETCH;
      end
      S_FETCH: begin
        Rd_Valid  = 1'b1;
        Rd_Row    = cr_q - ONE + tap_dr;
        Rd_Column = cc_q - ONE + tap_dc;
        Rd_Tap    = tap_q;
        if (Rd_Ready) begin
          // Tap 8 stays put until the window is accepted so the read port
          // goes quiet while the center is presented.
          if (tap_q == 4'd8) state_d = S_PRESENT;
          else               tap_d   = tap_q + 4'd1;
        end
      end
      S_PRESENT: begin
        Win_Valid  = 1'b1;
        Win_Row    = cr_q;
        Win_Column = cc_q;
        if (Win_Ready) begin
          tap_d   = 4'd0;
          state_d = S_FETCH;
          if (cc_q == LAST_COL) begin
            cc_d = ONE;
            if (cr_q == LAST_ROW) begin
              cr_d    = ONE;
              state_d = S_FINISH;
            end else begin
              cr_d = cr_q + ONE;
            end
          end else begin
            cc_d = cc_q + ONE;
          end
        end
      end
      default: begin
        Done    = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a Start or a handshake this cycle.
    if (Abort) begin
      state_d = S_IDLE;
      cr_d    = ONE;
      cc_d    = ONE;
      tap_d   = 4'd0;
    end

    Busy = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_sobel_window_scanner.sv
// tb/tb_sobel_window_scanner.sv - randomized self-checking bench for sobel_window_scanner
module tb_sobel_window_scanner;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int CW = 8;
  localparam int NWIN = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort, rd_ready, win_ready;
  logic          rd_valid, win_valid, busy, done;
  logic [CW-1:0] rd_row, rd_col, win_row, win_col;
  logic [3:0]    rd_tap;

  logic          start2, abort2, rd_ready2, win_ready2;
  logic          rd_valid2, win_valid2, busy2, done2;
  logic [CW-1:0] rd_row2, rd_col2, win_row2, win_col2;
  logic [3:0]    rd_tap2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sobel_window_scanner #(.IMG_W(W), .IMG_H(H), .COORD_W(CW)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .Abort(abort),
    .Rd_Valid(rd_valid), .Rd_Ready(rd_ready), .Rd_Row(rd_row), .Rd_Column(rd_col),
    .Rd_Tap(rd_tap), .Win_Valid(win_valid), .Win_Ready(win_ready),
    .Win_Row(win_row), .Win_Column(win_col), .Busy(busy), .Done(done)
  );

  sobel_window_scanner #(.IMG_W(3), .IMG_H(3), .COORD_W(CW)) dut3 (
    .Clk(clk), .Reset(rst), .Start(start2), .Abort(abort2),
    .Rd_Valid(rd_valid2), .Rd_Ready(rd_ready2), .Rd_Row(rd_row2), .Rd_Column(rd_col2),
    .Rd_Tap(rd_tap2), .Win_Valid(win_valid2), .Win_Ready(win_ready2),
    .Win_Row(win_row2), .Win_Column(win_col2), .Busy(busy2), .Done(done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: read number k belongs to window k/9, tap k%9. Window w is
  // center (w/(W-2)+1, w%(W-2)+1); tap t reads (cr-1+t/3, cc-1+t%3).
  task automatic run_scan(input int pct, input bit stall, input int abort_at,
                          input int reset_at, input int restart_at);
    int idx, w, cyc, wait_n, t, ecr, ecc;
    bit fin;
    idx = 0; w = 0; cyc = 0; wait_n = 0; fin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first_rd_valid", rd_valid, 1);
    while (!fin) begin
      rd_ready  = 1'b0;
      win_ready = 1'b0;
      start     = 1'b0;
      check("busy_in_scan", busy, 1);
      if (cyc > 3000) begin
        check("scan_timeout", 0, 1);
        fin = 1'b1;
      end else if (rd_valid) begin
        t   = idx % 9;
        ecr = (idx / 9) / (W - 2) + 1;
        ecc = (idx / 9) % (W - 2) + 1;
        check("rd_row", rd_row, ecr - 1 + t / 3);
        check("rd_col", rd_col, ecc - 1 + t % 3);
        check("rd_tap", rd_tap, t);
        check("rd_window", idx / 9, w);
        check("win_valid_during_rd", win_valid, 0);
        if (idx == abort_at) begin
          abort    = 1'b1;
          rd_ready = 1'b1;
          @(negedge clk);
          abort    = 1'b0;
          rd_ready = 1'b0;
          check("abort_busy", busy, 0);
          check("abort_rd_valid", rd_valid, 0);
          check("abort_done", done, 0);
          fin = 1'b1;
        end else if (idx == reset_at) begin
          rd_ready = 1'b1;
          #2 rst = 1'b1;
          #1;
          check("rst_rd_outs", {rd_valid, rd_row, rd_col, rd_tap}, 0);
          check("rst_win_outs", {win_valid, win_row, win_col, busy, done}, 0);
          @(negedge clk);
          rst      = 1'b0;
          rd_ready = 1'b0;
          fin = 1'b1;
        end else begin
          if (idx == restart_at) start = 1'b1;
          rd_ready = (pct >= 100) || ($urandom_range(0, 99) < pct);
          if (rd_ready) idx++;
        end
      end else if (win_valid) begin
        check("win_row", win_row, w / (W - 2) + 1);
        check("win_col", win_col, w % (W - 2) + 1);
        check("reads_before_win", idx, 9 * (w + 1));
        check("done_during_win", done, 0);
        if (stall && wait_n < 5) begin
          wait_n++;
        end else begin
          win_ready = 1'b1;
          wait_n    = 0;
          w++;
        end
      end else begin
        check("done_pulse", done, 1);
        check("windows_total", w, NWIN);
        check("reads_total", idx, 9 * NWIN);
        if (pct >= 100 && !stall) check("scan_cycles", cyc, 40);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        fin = 1'b1;
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    rd_ready  = 1'b0;
    win_ready = 1'b0;
    start     = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; abort = 1'b0; rd_ready = 1'b0; win_ready = 1'b0;
    start2 = 1'b0; abort2 = 1'b0; rd_ready2 = 1'b1; win_ready2 = 1'b1;
    #12;
    check("reset_rd_outs", {rd_valid, rd_row, rd_col, rd_tap}, 0);
    check("reset_win_outs", {win_valid, win_row, win_col, busy, done}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 3x3 frame: a single window at (1,1).
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check("f3_rd_valid", rd_valid2, 1);
      check("f3_rd_row", rd_row2, k / 3);
      check("f3_rd_col", rd_col2, k % 3);
      check("f3_rd_tap", rd_tap2, k);
      @(negedge clk);
    end
    check("f3_win_valid", win_valid2, 1);
    check("f3_rd_quiet", rd_valid2, 0);
    check("f3_win_center", {win_row2, win_col2}, {8'd1, 8'd1});
    @(negedge clk);
    check("f3_done", done2, 1);
    @(negedge clk);
    check("f3_idle", {done2, busy2}, 0);

    run_scan(100, 1'b0, -1, -1, -1);
    run_scan(50, 1'b1, -1, -1, -1);

    run_scan(100, 1'b0, 13, -1, -1);
    repeat (2) begin
      @(negedge clk);
      check("post_abort_idle", {busy, done, rd_valid}, 0);
    end
    run_scan(100, 1'b0, -1, -1, -1);

    run_scan(50, 1'b0, -1, 20, 5);
    check("post_reset_idle", {busy, done, rd_valid}, 0);
    run_scan(100, 1'b0, -1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
